ex_mc: RTL and testbench
========================

# ex_mc

Parametrised multi-cycle execute stage. It takes one decoded instruction per handshake and executes add/sub/compare, logic, shift, iterative multiply or branch. It registers the result, writeback control and branch redirect for the writeback stage, and keeps a registered condition-flag set that branches consume. It sits between the register-read stage and writeback, replacing the single-cycle execute stage. It adds width parametrisation, a real multiplier, and a valid/ready handshake with back-pressure.

## Interface
- XLEN, 32, datapath width; must be a power of two ≥ 8.
- PCW, 16, program-counter width; PCW ≤ XLEN.
- RAW, 4, register-address width.
- MUL_BITS, 4, multiplier bits retired per cycle; must divide XLEN.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid_i  in  1  instruction present.
- in_ready_o  out  1  unit can accept.
- op_i  in  4  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL, 9 MULHU, 10 BR (relative), 11 BRA (absolute), 12 CMP; 13–15 reserved.
- rd_value_i  in  XLEN  destination operand (opr0).
- rs_value_i  in  XLEN  source operand.
- imm_value_i  in  XLEN  immediate.
- immf_i  in  1  opr1 = imm_value_i when 1, else rs_value_i.
- rd_addr_i  in  RAW  destination register; bits [2:0] are the branch condition for BR/BRA.
- pc_value_i  in  PCW  PC of the instruction.
- out_valid_o  out  1  result valid, one-cycle pulse per instruction.
- result_o  out  XLEN  result, or branch target zero-extended.
- rd_addr_o  out  RAW  destination register.
- wb_en_o  out  1  write result to rd_addr_o.
- branch_en_o  out  1  branch taken; target is on result_o[PCW-1:0].
- flags_o  out  5  registered flags {Z,P,N,C,V}.

## Operation
- Accept: in_valid_i & in_ready_o at a rising edge. in_ready_o = (state == IDLE).
- States:
  - IDLE: a non-MUL op completes on the accept edge. A MUL/MULHU op loads the operands and a counter of XLEN/MUL_BITS−1 and goes to MUL.
  - MUL: retires MUL_BITS of opr1 per edge as a radix-2^MUL_BITS shift-add into a 2·XLEN accumulator. On the edge where the counter reaches 0 it completes and returns to IDLE.
- Arithmetic: operands are unsigned XLEN bits and results are truncated to XLEN.
  - ADD/SUB/CMP: C = carry out (ADD) or borrow (SUB/CMP). V = signed overflow.
  - MUL yields the low XLEN bits of rd×opr1. MULHU yields the high XLEN bits.
- Shifts: amount = opr1[log2(XLEN)−1:0], data = rd_value_i. C = last bit shifted out; amount 0 gives result = data and C = 0.
- Flag updates: Z/P/N are derived from the result (P = non-zero and MSB 0).
  - ADD/SUB/CMP/shifts update all five flags.
  - Logic ops and MUL/MULHU update Z/P/N; C and V hold.
  - BR/BRA and reserved ops leave the flags unchanged.
- Branch conditions from cc = rd_addr_i[2:0]: 0 always, 1 Z, 2 !Z, 3 N, 4 P, 5 C, 6 V, 7 never. The condition is evaluated on the flag register at the accept edge, i.e. the flags of the previously completed instruction.
- Branch target: BR = pc_value_i + opr1[PCW−1:0], mod 2^PCW. BRA = opr1[PCW−1:0].
- wb_en_o = 1 for ADD, SUB, logic, shift and MUL ops. It is 0 for CMP, BR, BRA and reserved ops.
- Reserved ops still produce out_valid_o with result 0, wb_en_o = 0 and branch_en_o = 0.

## Timing
- Non-MUL op: accepted at edge k, outputs valid during cycle k+1 (latency 1). Back-to-back acceptance is possible every cycle.
- MUL op: accepted at edge k, completes at edge k+XLEN/MUL_BITS. in_ready_o is low from cycle k+1 until that completion edge, and the next accept is at the earliest on the edge after completion.
- out_valid_o, wb_en_o and branch_en_o are single-cycle pulses. There is no output back-pressure.
- Flags are written on the completion edge of the producing op, so a branch accepted on any later edge sees them.
- Reset (also mid-MUL):
  - State returns to IDLE and the accumulator and counter clear.
  - out_valid_o, wb_en_o and branch_en_o go to 0, and result_o, rd_addr_o and flags_o go to 0.
  - in_ready_o = 1 in the cycle after reset deasserts.
  - An in-flight multiply is dropped with no out_valid_o.
- An accept coincident with rst is ignored.

## Test plan
- ADD rd=0x7FFFFFFF, opr1=1 → result 0x80000000, wb_en=1, flags N=1, V=1, C=0, Z=0, one cycle after accept.
- MUL 0xFFFFFFFF×0xFFFFFFFF (XLEN=32, MUL_BITS=4) → result 0x00000001, out_valid exactly 8 edges after accept, in_ready low for cycles k+1..k+8. MULHU on the same operands → 0xFFFFFFFE.
- CMP 5,5 then BR cc=1, pc=0x0100, imm=0x0010 → CMP gives wb_en=0 and Z=1; BR gives branch_en=1, result 0x0110. The same BR after CMP 5,6 → branch_en=0.
- SRL 0x80000001 by 1 → 0x40000000, C=1. SRA 0x80000000 by 31 → 0xFFFFFFFF, C=0. SLL with amount 0 → unchanged data, C=0.
- Assert rst on the third cycle of a MUL → no out_valid, flags 0, in_ready=1 after release. A following ADD 2+3 → result 5.
- Stream ADD, XOR, SLL, AND on consecutive cycles with in_valid held high → four out_valid pulses on consecutive cycles with correct rd_addr_o ordering. Then a MUL followed by an ADD held valid → ADD accepted only after MUL completion, with results in order.

Source files
------------

// File: rtl/ex_mc.sv
// Multi-cycle execute stage: single-cycle ALU/shift/branch ops plus an iterative
// radix-2^MUL_BITS multiplier, with registered result, writeback control and flags.
module ex_mc #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PCW      = 16,
  parameter int unsigned RAW      = 4,
  parameter int unsigned MUL_BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] rd_value_i,
  input  logic [XLEN-1:0] rs_value_i,
  input  logic [XLEN-1:0] imm_value_i,
  input  logic            immf_i,
  input  logic [RAW-1:0]  rd_addr_i,
  input  logic [PCW-1:0]  pc_value_i,
  output logic            out_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [RAW-1:0]  rd_addr_o,
  output logic            wb_en_o,
  output logic            branch_en_o,
  output logic [4:0]      flags_o
);

  localparam int unsigned SHW   = $clog2(XLEN);
  localparam int unsigned MSB   = XLEN - 1;
  localparam int unsigned STEPS = XLEN / MUL_BITS;
  localparam int unsigned CNTW  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNTW-1:0] CntInit = CNTW'(STEPS - 1);

  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpSub   = 4'd1;
  localparam logic [3:0] OpAnd   = 4'd2;
  localparam logic [3:0] OpOr    = 4'd3;
  localparam logic [3:0] OpXor   = 4'd4;
  localparam logic [3:0] OpSll   = 4'd5;
  localparam logic [3:0] OpSrl   = 4'd6;
  localparam logic [3:0] OpSra   = 4'd7;
  localparam logic [3:0] OpMul   = 4'd8;
  localparam logic [3:0] OpMulhu = 4'd9;
  localparam logic [3:0] OpBr    = 4'd10;
  localparam logic [3:0] OpBra   = 4'd11;
  localparam logic [3:0] OpCmp   = 4'd12;

  typedef enum logic {StIdle, StMul} state_e;

  // Flag vector layout: {Z, P, N, C, V}
  function automatic logic [2:0] zpn(input logic [XLEN-1:0] v);
    return {v == '0, ~v[XLEN-1] & (v != '0), v[XLEN-1]};
  endfunction

  state_e                state_q, state_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [2*XLEN-1:0]     mcand_q, mcand_d;
  logic [XLEN-1:0]       mplier_q, mplier_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  mul_hi_q, mul_hi_d;
  logic [RAW-1:0]        mul_rd_q, mul_rd_d;
  logic                  out_valid_q, out_valid_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic [RAW-1:0]        rd_addr_q, rd_addr_d;
  logic                  wb_en_q, wb_en_d;
  logic                  branch_en_q, branch_en_d;
  logic [4:0]            flags_q, flags_d;

  logic [XLEN-1:0]       opr1;
  logic [SHW-1:0]        shamt;
  logic [XLEN:0]         sum, diff, sll_ext, srl_ext, sra_ext;
  logic [PCW-1:0]        br_target;
  logic                  cc_true;
  logic [XLEN-1:0]       exe_result;
  logic                  exe_c, exe_v, exe_upd, exe_wb, exe_br;
  logic [4:0]            exe_flags;
  logic [2*XLEN-1:0]     partial, acc_sum;
  logic [XLEN-1:0]       mul_result;

  // Single-cycle execute datapath for everything except the multiplier.
  always_comb begin
    opr1      = immf_i ? imm_value_i : rs_value_i;
    shamt     = opr1[SHW-1:0];
    sum       = {1'b0, rd_value_i} + {1'b0, opr1};
    diff      = {1'b0, rd_value_i} - {1'b0, opr1};
    // One extra bit on the shift-out side captures the last bit shifted out.
    sll_ext   = {1'b0, rd_value_i} << shamt;
    srl_ext   = {rd_value_i, 1'b0} >> shamt;
    sra_ext   = $signed({rd_value_i, 1'b0}) >>> shamt;
    br_target = (op_i == OpBra) ? opr1[PCW-1:0] : pc_value_i + opr1[PCW-1:0];
    case (rd_addr_i[2:0])
      3'd0:    cc_true = 1'b1;
      3'd1:    cc_true = flags_q[4];
      3'd2:    cc_true = ~flags_q[4];
      3'd3:    cc_true = flags_q[2];
      3'd4:    cc_true = flags_q[3];
      3'd5:    cc_true = flags_q[1];
      3'd6:    cc_true = flags_q[0];
      default: cc_true = 1'b0;
    endcase
    exe_result = '0;
    exe_c      = flags_q[1];
    exe_v      = flags_q[0];
    exe_upd    = 1'b0;
    exe_wb     = 1'b0;
    exe_br     = 1'b0;
    case (op_i)
      OpAdd: begin
        exe_result = sum[XLEN-1:0];
        exe_c      = sum[XLEN];
        exe_v      = (rd_value_i[MSB] == opr1[MSB]) && (sum[MSB] != rd_value_i[MSB]);
        exe_upd    = 1'b1;
        exe_wb     = 1'b1;
      end
      OpSub, OpCmp: begin
        exe_result = diff[XLEN-1:0];
        exe_c      = diff[XLEN];
        exe_v      = (rd_value_i[MSB] != opr1[MSB]) && (diff[MSB] != rd_value_i[MSB]);
        exe_upd    = 1'b1;
        exe_wb     = (op_i == OpSub);
      end
      OpAnd, OpOr, OpXor: begin
        exe_result = (op_i == OpAnd) ? (rd_value_i & opr1) :
                     (op_i == OpOr)  ? (rd_value_i | opr1) : (rd_value_i ^ opr1);
        exe_upd    = 1'b1;
        exe_wb     = 1'b1;
      end
      OpSll: begin
        exe_result = sll_ext[XLEN-1:0];
        exe_c      = sll_ext[XLEN];
        exe_v      = 1'b0;
        exe_upd    = 1'b1;
        exe_wb     = 1'b1;
      end
      OpSrl, OpSra: begin
        exe_result = (op_i == OpSrl) ? srl_ext[XLEN:1] : sra_ext[XLEN:1];
        exe_c      = (op_i == OpSrl) ? srl_ext[0] : sra_ext[0];
        exe_v      = 1'b0;
        exe_upd    = 1'b1;
        exe_wb     = 1'b1;
      end
      OpBr, OpBra: begin
        exe_result = XLEN'(br_target);
        exe_br     = cc_true;
      end
      default: ;
    endcase
    exe_flags = exe_upd ? {zpn(exe_result), exe_c, exe_v} : flags_q;
  end

  // One radix-2^MUL_BITS step: add the shifted multiplicand for each set digit bit.
  always_comb begin
    partial = '0;
    for (int unsigned b = 0; b < MUL_BITS; b++) begin
      if (mplier_q[b]) partial = partial + (mcand_q << b);
    end
    acc_sum    = acc_q + partial;
    mul_result = mul_hi_q ? acc_sum[2*XLEN-1:XLEN] : acc_sum[XLEN-1:0];
  end

  // Next-state logic for the FSM, multiplier registers and output registers.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    mul_hi_d    = mul_hi_q;
    mul_rd_d    = mul_rd_q;
    out_valid_d = 1'b0;
    wb_en_d     = 1'b0;
    branch_en_d = 1'b0;
    result_d    = result_q;
    rd_addr_d   = rd_addr_q;
    flags_d     = flags_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          if (op_i == OpMul || op_i == OpMulhu) begin
            acc_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, rd_value_i};
            mplier_d = opr1;
            cnt_d    = CntInit;
            mul_hi_d = (op_i == OpMulhu);
            mul_rd_d = rd_addr_i;
            state_d  = StMul;
          end else begin
            out_valid_d = 1'b1;
            result_d    = exe_result;
            rd_addr_d   = rd_addr_i;
            wb_en_d     = exe_wb;
            branch_en_d = exe_br;
            flags_d     = exe_flags;
          end
        end
      end
      StMul: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << MUL_BITS;
        mplier_d = mplier_q >> MUL_BITS;
        cnt_d    = cnt_q - CNTW'(1);
        if (cnt_q == '0) begin
          state_d     = StIdle;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          result_d    = mul_result;
          rd_addr_d   = mul_rd_q;
          wb_en_d     = 1'b1;
          flags_d     = {zpn(mul_result), flags_q[1:0]};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      mul_hi_q    <= 1'b0;
      mul_rd_q    <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      rd_addr_q   <= '0;
      wb_en_q     <= 1'b0;
      branch_en_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      mul_hi_q    <= mul_hi_d;
      mul_rd_q    <= mul_rd_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      rd_addr_q   <= rd_addr_d;
      wb_en_q     <= wb_en_d;
      branch_en_q <= branch_en_d;
      flags_q     <= flags_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign rd_addr_o   = rd_addr_q;
  assign wb_en_o     = wb_en_q;
  assign branch_en_o = branch_en_q;
  assign flags_o     = flags_q;

endmodule

// File: tb/tb_ex_mc.sv
// Bench for ex_mc: directed vectors, a behavioural model computing expected outputs
// per completion edge, and one per-cycle compare process.
module tb_ex_mc;

  localparam int STEPS = 8;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [31:0] rd_value = '0, rs_value = '0, imm_value = '0;
  logic        immf = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [15:0] pc_value = '0;
  logic        out_valid, wb_en, branch_en;
  logic [31:0] result;
  logic [3:0]  rd_addr_out;
  logic [4:0]  flags;

  always #5 clk = ~clk;

  ex_mc #(.XLEN(32), .PCW(16), .RAW(4), .MUL_BITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .rd_value_i  (rd_value),
    .rs_value_i  (rs_value),
    .imm_value_i (imm_value),
    .immf_i      (immf),
    .rd_addr_i   (rd_addr),
    .pc_value_i  (pc_value),
    .out_valid_o (out_valid),
    .result_o    (result),
    .rd_addr_o   (rd_addr_out),
    .wb_en_o     (wb_en),
    .branch_en_o (branch_en),
    .flags_o     (flags)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        wb;
    logic        br;
    logic [4:0]  fl;
  } exp_t;

  exp_t       exp_q [int];
  int         cyc = 0;
  int         mul_acc = -1;
  int         busy_until = -1;
  int         n_vec = 0;
  int         n_err = 0;
  bit         chk_en = 1'b0;
  logic [4:0] mflags = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // The unit can take an instruction at edge e unless a multiply is still running.
  function automatic bit model_ready(input int e);
    return !(e > mul_acc && e <= busy_until);
  endfunction

  function automatic logic cond(input logic [2:0] cc, input logic [4:0] f);
    case (cc)
      3'd0: return 1'b1;
      3'd1: return f[4];
      3'd2: return !f[4];
      3'd3: return f[2];
      3'd4: return f[3];
      3'd5: return f[1];
      3'd6: return f[0];
      default: return 1'b0;
    endcase
  endfunction

  // What one instruction must produce, given the flags left by the previous one.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [15:0] pc, input logic [3:0] rda,
                                 input logic [4:0] f);
    exp_t        x;
    logic [63:0] w;
    longint      ls;
    int          amt;
    logic        c, v;
    logic [15:0] t;
    x.res = '0; x.rd = rda; x.wb = 1'b0; x.br = 1'b0; x.fl = f;
    c = f[1]; v = f[0];
    amt = int'(b[4:0]);
    case (o)
      4'd0: begin
        w = {32'b0, a} + {32'b0, b};
        x.res = w[31:0]; c = w[32];
        ls = longint'($signed(a)) + longint'($signed(b));
        v = (ls > SMAX) || (ls < SMIN);
        x.wb = 1'b1;
      end
      4'd1, 4'd12: begin
        x.res = a - b; c = (a < b);
        ls = longint'($signed(a)) - longint'($signed(b));
        v = (ls > SMAX) || (ls < SMIN);
        x.wb = (o == 4'd1);
      end
      4'd2: begin x.res = a & b; x.wb = 1'b1; end
      4'd3: begin x.res = a | b; x.wb = 1'b1; end
      4'd4: begin x.res = a ^ b; x.wb = 1'b1; end
      4'd5: begin x.res = a << amt; c = (amt == 0) ? 1'b0 : a[32-amt]; v = 1'b0; x.wb = 1'b1; end
      4'd6: begin x.res = a >> amt; c = (amt == 0) ? 1'b0 : a[amt-1]; v = 1'b0; x.wb = 1'b1; end
      4'd7: begin
        x.res = $signed(a) >>> amt; c = (amt == 0) ? 1'b0 : a[amt-1]; v = 1'b0; x.wb = 1'b1;
      end
      4'd8, 4'd9: begin
        w = {32'b0, a} * {32'b0, b};
        x.res = (o == 4'd8) ? w[31:0] : w[63:32];
        x.wb = 1'b1;
      end
      4'd10, 4'd11: begin
        t = (o == 4'd10) ? pc + b[15:0] : b[15:0];
        x.res = {16'b0, t};
        x.br = cond(rda[2:0], f);
      end
      default: ;
    endcase
    if (o <= 4'd9 || o == 4'd12)
      x.fl = {x.res == 32'd0, (x.res != 32'd0) && !x.res[31], x.res[31], c, v};
    return x;
  endfunction

  task automatic model_accept(input int e, input logic [3:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [3:0] rda,
                              input logic [15:0] pc);
    exp_t x;
    x = model(o, a, b, pc, rda, mflags);
    mflags = x.fl;
    if (o == 4'd8 || o == 4'd9) begin
      mul_acc = e;
      busy_until = e + STEPS;
      exp_q[e + STEPS] = x;
    end else begin
      exp_q[e] = x;
    end
  endtask

  // Present an instruction and hold it until the model says it is taken.
  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] rs,
                      input logic [31:0] imm, input logic f, input logic [3:0] rda,
                      input logic [15:0] pc);
    int guard;
    op = o; rd_value = a; rs_value = rs; imm_value = imm; immf = f;
    rd_addr = rda; pc_value = pc; in_valid = 1'b1;
    guard = 0;
    while (!model_ready(cyc + 1) && guard < 64) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 64) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got no accept, expected one within 64 cycles");
    end
    model_accept(cyc + 1, o, a, f ? imm : rs, rda, pc);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Per-cycle comparison of the DUT against the model's expectation for this edge.
  always @(negedge clk) begin
    exp_t x;
    if (chk_en) begin
      if (exp_q.exists(cyc)) begin
        x = exp_q[cyc];
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("result", result, x.res);
        chk("rd_addr", 32'(rd_addr_out), 32'(x.rd));
        chk("wb_en", 32'(wb_en), 32'(x.wb));
        chk("branch_en", 32'(branch_en), 32'(x.br));
        chk("flags", 32'(flags), 32'(x.fl));
      end else begin
        chk("quiet_valid", 32'(out_valid), 32'd0);
        chk("quiet_wb", 32'(wb_en), 32'd0);
        chk("quiet_br", 32'(branch_en), 32'd0);
      end
      chk("in_ready", 32'(in_ready), 32'(model_ready(cyc + 1)));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    busy_until = cyc;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_wb", 32'(wb_en), 32'd0);
    chk("rst_br", 32'(branch_en), 32'd0);
    chk("rst_rd", 32'(rd_addr_out), 32'd0);
    chk_en = 1'b1;

    // ADD overflow into the sign bit
    send(4'd0, 32'h7FFF_FFFF, 32'h0, 32'h1, 1'b1, 4'd3, 16'h0);
    chk("lit_add_res", result, 32'h8000_0000);
    chk("lit_add_wb", 32'(wb_en), 32'd1);
    chk("lit_add_flags", 32'(flags), 32'h05);

    // MUL: eight edges from accept to completion
    send(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 4'd5, 16'h0);
    chk("lit_mul_busy", 32'(in_ready), 32'd0);
    repeat (7) @(posedge clk);
    #1 chk("lit_mul_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 chk("lit_mul_done", 32'(out_valid), 32'd1);
    chk("lit_mul_res", result, 32'h0000_0001);
    chk("lit_mul_flags", 32'(flags), 32'h09);
    send(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 4'd6, 16'h0);
    repeat (8) @(posedge clk);
    #1 chk("lit_mulhu_res", result, 32'hFFFF_FFFE);

    // CMP then conditional branch on Z
    send(4'd12, 32'd5, 32'd0, 32'd5, 1'b1, 4'd7, 16'h0);
    chk("lit_cmp_wb", 32'(wb_en), 32'd0);
    chk("lit_cmp_flags", 32'(flags), 32'h10);
    send(4'd10, 32'd0, 32'd0, 32'h10, 1'b1, 4'd1, 16'h0100);
    chk("lit_br_taken", 32'(branch_en), 32'd1);
    chk("lit_br_target", result, 32'h0000_0110);
    send(4'd12, 32'd5, 32'd0, 32'd6, 1'b1, 4'd7, 16'h0);
    send(4'd10, 32'd0, 32'd0, 32'h10, 1'b1, 4'd1, 16'h0100);
    chk("lit_br_nottaken", 32'(branch_en), 32'd0);

    // Shifts
    send(4'd6, 32'h8000_0001, 32'd0, 32'd1, 1'b1, 4'd2, 16'h0);
    chk("lit_srl_res", result, 32'h4000_0000);
    chk("lit_srl_c", 32'(flags[1]), 32'd1);
    send(4'd7, 32'h8000_0000, 32'd31, 32'd0, 1'b0, 4'd2, 16'h0);
    chk("lit_sra_res", result, 32'hFFFF_FFFF);
    chk("lit_sra_c", 32'(flags[1]), 32'd0);
    send(4'd5, 32'h1234_5678, 32'd0, 32'd0, 1'b1, 4'd2, 16'h0);
    chk("lit_sll0_res", result, 32'h1234_5678);
    chk("lit_sll0_c", 32'(flags[1]), 32'd0);

    // Reset in the middle of a multiply drops it
    send(4'd8, 32'd7, 32'd9, 32'd0, 1'b0, 4'd8, 16'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    busy_until = cyc;
    mflags = '0;
    exp_q.delete();
    chk("lit_rstmul_valid", 32'(out_valid), 32'd0);
    chk("lit_rstmul_flags", 32'(flags), 32'd0);
    chk("lit_rstmul_ready", 32'(in_ready), 32'd1);
    send(4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 4'd9, 16'h0);
    chk("lit_add5", result, 32'd5);

    // Back-to-back stream, then MUL with an ADD queued behind it
    send(4'd0, 32'd10, 32'd20, 32'd0, 1'b0, 4'd1, 16'h0);
    send(4'd4, 32'hF0F0_F0F0, 32'd0, 32'hFF00_FF00, 1'b1, 4'd2, 16'h0);
    send(4'd5, 32'd1, 32'd4, 32'd0, 1'b0, 4'd3, 16'h0);
    send(4'd2, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'd0, 1'b0, 4'd4, 16'h0);
    send(4'd8, 32'd3, 32'd7, 32'd0, 1'b0, 4'd5, 16'h0);
    send(4'd0, 32'd100, 32'd0, 32'd1, 1'b1, 4'd6, 16'h0);
    chk("lit_after_mul_add", result, 32'd101);

    // Absolute branch, reserved op, SUB overflow, OR, never-branch
    send(4'd11, 32'd0, 32'h0001_BEEF, 32'd0, 1'b0, 4'd0, 16'h1234);
    send(4'd13, 32'd1, 32'd2, 32'd3, 1'b0, 4'd11, 16'h0);
    send(4'd1, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 4'd12, 16'h0);
    send(4'd3, 32'h0000_00F0, 32'h0000_000F, 32'd0, 1'b0, 4'd13, 16'h0);
    send(4'd10, 32'd0, 32'd0, 32'h0000_FFF0, 1'b1, 4'd7, 16'hFFF0);
    send(4'd9, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0, 4'd14, 16'h0);

    repeat (12) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
